// File: rtl/obstacle_spawn_timer_pkg.sv
// Shared types and default widths for the obstacle spawn timer slice.
package obstacle_spawn_pkg;

    localparam int unsigned DEF_RND_W     = 4;
    localparam int unsigned DEF_FILL_BITS = 4;
    localparam int unsigned DEF_GAP_W     = DEF_RND_W + DEF_FILL_BITS;
    localparam int unsigned STATS_W       = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        SPAWN
    } state_t;

endpackage

// File: rtl/obstacle_spawn_timer_if.sv
// Spawn request handshake between the timer (master) and obstacle/render logic (slave).
interface obstacle_spawn_timer_if
    import obstacle_spawn_pkg::*;
#(
    parameter int unsigned GAP_W = DEF_GAP_W
);
    logic             spawn_valid;
    logic             spawn_ready;
    logic [GAP_W-1:0] spawn_gap;

    modport master (output spawn_valid, output spawn_gap, input spawn_ready);
    modport slave  (input spawn_valid, input spawn_gap, output spawn_ready);
endinterface

// File: rtl/obstacle_spawn_timer_gap_counter.sv
// Loadable frame-gap down-counter; load has priority over decrement.
module spawn_gap_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_one
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= value - W'(1);
        end
    end

    assign is_one = (value == W'(1));
endmodule

// File: rtl/obstacle_spawn_timer.sv
// Obstacle spawn timer: loads a {rnd,1..1} frame gap, counts frames, then offers a spawn request.
// Optional SPAWN_STATS_EN adds saturating accepted-spawn and stall-cycle counters.
module obstacle_spawn_timer
    import obstacle_spawn_pkg::*;
#(
    parameter int unsigned RND_W     = DEF_RND_W,
    parameter int unsigned FILL_BITS = DEF_FILL_BITS,
    parameter int unsigned GAP_W     = RND_W + FILL_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  game_run,
    input  logic                  frame_tick,
    input  logic [RND_W-1:0]      rnd,
    output logic                  rnd_step,
    obstacle_spawn_timer_if.master spawn
`ifdef SPAWN_STATS_EN
    ,
    output logic [STATS_W-1:0]    spawn_count,
    output logic [STATS_W-1:0]    stall_count
`endif
);
    state_t           state_q, state_d;
    logic             rnd_step_q, valid_q;
    logic [GAP_W-1:0] gap_q, load_val, cnt_value;
    logic             cnt_load, cnt_dec, cnt_is_one;

    assign load_val = {rnd, {FILL_BITS{1'b1}}};

    spawn_gap_counter #(.W(GAP_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        // game_run low overrides ticks and ready in every state
        if (!game_run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = LOAD;
                LOAD: begin
                    cnt_load = 1'b1;
                    state_d  = COUNT;
                end
                COUNT: begin
                    if (frame_tick) begin
                        cnt_dec = 1'b1;
                        if (cnt_is_one) state_d = SPAWN;
                    end
                end
                SPAWN: if (spawn.spawn_ready) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rnd_step_q <= 1'b0;
            valid_q    <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            rnd_step_q <= (state_d == LOAD);
            valid_q    <= (state_d == SPAWN);
            if (cnt_load) gap_q <= load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == COUNT) assert (cnt_value != '0);
    end

    assign rnd_step          = rnd_step_q;
    assign spawn.spawn_valid = valid_q;
    assign spawn.spawn_gap   = gap_q;

`ifdef SPAWN_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spawn_count <= '0;
            stall_count <= '0;
        end else begin
            if (state_q == SPAWN && game_run && spawn.spawn_ready && spawn_count != '1)
                spawn_count <= spawn_count + STATS_W'(1);
            if (state_q == SPAWN && !spawn.spawn_ready && stall_count != '1)
                stall_count <= stall_count + STATS_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_obstacle_spawn_timer.sv
// Self-checking bench for obstacle_spawn_timer: constant vector table, directed corner sequences, random run vs. model.
module tb_obstacle_spawn_timer;
    import obstacle_spawn_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_run;
    logic       frame_tick;
    logic [3:0] rnd;
    logic       rnd_step;
`ifdef SPAWN_STATS_EN
    logic [15:0] spawn_count, stall_count;
`endif

    obstacle_spawn_timer_if #(.GAP_W(8)) sif ();

    obstacle_spawn_timer #(.RND_W(4), .FILL_BITS(4), .GAP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .game_run   (game_run),
        .frame_tick (frame_tick),
        .rnd        (rnd),
        .rnd_step   (rnd_step),
        .spawn      (sif)
`ifdef SPAWN_STATS_EN
        ,
        .spawn_count(spawn_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: frames left to wait, pending consume, pending offer
    bit m_loading, m_offer;
    int m_left, m_gap, m_spawns, m_stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_offer = 0; m_left = 0; m_gap = 0; m_spawns = 0; m_stalls = 0;
    endtask

    task automatic model_edge(input bit gr, input bit tick, input logic [3:0] r, input bit ready);
        if (m_offer && !ready && m_stalls < 65535) m_stalls++;
        if (!gr) begin
            m_loading = 0; m_offer = 0; m_left = 0;
        end else if (m_loading) begin
            m_gap = int'(r) * 16 + 15;
            m_left = m_gap;
            m_loading = 0;
        end else if (m_offer) begin
            if (ready) begin
                m_offer = 0;
                m_loading = 1;
                if (m_spawns < 65535) m_spawns++;
            end
        end else if (m_left > 0) begin
            if (tick) begin
                m_left--;
                if (m_left == 0) m_offer = 1;
            end
        end else begin
            m_loading = 1;
        end
    endtask

    task automatic check_model();
        check("model_rnd_step", 32'(rnd_step), 32'(m_loading));
        check("model_valid", 32'(sif.spawn_valid), 32'(m_offer));
        check("model_gap", 32'(sif.spawn_gap), 32'(m_gap));
`ifdef SPAWN_STATS_EN
        check("model_spawn_count", 32'(spawn_count), 32'(m_spawns));
        check("model_stall_count", 32'(stall_count), 32'(m_stalls));
`endif
    endtask

    task automatic step(input bit gr, input bit tick, input logic [3:0] r, input bit ready);
        game_run = gr; frame_tick = tick; rnd = r; sif.spawn_ready = ready;
        @(posedge clk);
        model_edge(gr, tick, r, ready);
        #1;
        check_model();
    endtask

    task automatic run_to_spawn(input logic [3:0] r);
        int n = 0;
        while (!m_offer && n < 300) begin
            step(1, 1, r, 0);
            n++;
        end
        check("spawn_reached", 32'(sif.spawn_valid), 32'd1);
    endtask

    typedef struct {
        bit         gr;
        bit         tick;
        logic [3:0] r;
        bit         ready;
        bit         e_step;
        bit         e_valid;
        logic [7:0] e_gap;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{gr:0, tick:0, r:4'h0, ready:0, e_step:0, e_valid:0, e_gap:8'h00};
        tbl[1] = '{gr:1, tick:0, r:4'h3, ready:0, e_step:1, e_valid:0, e_gap:8'h00};
        tbl[2] = '{gr:1, tick:1, r:4'h0, ready:0, e_step:0, e_valid:0, e_gap:8'h0F};
        tbl[3] = '{gr:0, tick:1, r:4'hA, ready:1, e_step:0, e_valid:0, e_gap:8'h0F};
        tbl[4] = '{gr:1, tick:0, r:4'h5, ready:0, e_step:1, e_valid:0, e_gap:8'h0F};
        tbl[5] = '{gr:1, tick:0, r:4'h9, ready:1, e_step:0, e_valid:0, e_gap:8'h9F};
        tbl[6] = '{gr:1, tick:1, r:4'h9, ready:1, e_step:0, e_valid:0, e_gap:8'h9F};

        reset = 1'b0; game_run = 0; frame_tick = 0; rnd = '0; sif.spawn_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rnd_step", 32'(rnd_step), 32'd0);
        check("reset_valid", 32'(sif.spawn_valid), 32'd0);
        check("reset_gap", 32'(sif.spawn_gap), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].gr, tbl[i].tick, tbl[i].r, tbl[i].ready);
            check($sformatf("tbl%0d_step", i), 32'(rnd_step), 32'(tbl[i].e_step));
            check($sformatf("tbl%0d_valid", i), 32'(sif.spawn_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_gap", i), 32'(sif.spawn_gap), 32'(tbl[i].e_gap));
        end

        // Minimum gap: exactly 15 ticks after LOAD
        step(0, 0, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        check("min_step_pulse", 32'(rnd_step), 32'd1);
        step(1, 0, 4'h0, 0);
        check("min_step_once", 32'(rnd_step), 32'd0);
        check("min_gap", 32'(sif.spawn_gap), 32'h0F);
        for (int i = 0; i < 14; i++) step(1, 1, 4'h7, 0);
        check("min_no_early_valid", 32'(sif.spawn_valid), 32'd0);
        step(1, 1, 4'h7, 0);
        check("min_valid_after_15", 32'(sif.spawn_valid), 32'd1);

        // Stall with ticks: request held, gap stable
        for (int i = 0; i < 5; i++) step(1, 1, 4'h3, 0);
        check("stall_valid_held", 32'(sif.spawn_valid), 32'd1);
        check("stall_gap_stable", 32'(sif.spawn_gap), 32'h0F);
        step(1, 1, 4'h3, 1);
        check("accept_drops_valid", 32'(sif.spawn_valid), 32'd0);
        check("accept_rnd_step", 32'(rnd_step), 32'd1);
        step(1, 0, 4'hF, 0);
        check("max_gap", 32'(sif.spawn_gap), 32'hFF);

        // Maximum gap with rnd changing during COUNT
        for (int i = 0; i < 254; i++) step(1, 1, 4'($urandom), 0);
        check("max_no_early_valid", 32'(sif.spawn_valid), 32'd0);
        step(1, 1, 4'h0, 0);
        check("max_valid_after_255", 32'(sif.spawn_valid), 32'd1);
        check("max_gap_held", 32'(sif.spawn_gap), 32'hFF);

        // Abort in SPAWN beats ready
        step(0, 1, 4'h0, 1);
        check("abort_spawn_valid", 32'(sif.spawn_valid), 32'd0);
        check("abort_spawn_no_step", 32'(rnd_step), 32'd0);
        step(0, 0, 4'h0, 1);
        check("abort_idle_no_step", 32'(rnd_step), 32'd0);

        // Async reset mid-COUNT
        step(1, 0, 4'h0, 0);
        step(1, 0, 4'h2, 0);
        check("rst_pre_gap", 32'(sif.spawn_gap), 32'h2F);
        for (int i = 0; i < 3; i++) step(1, 1, 4'h2, 0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_gap", 32'(sif.spawn_gap), 32'd0);
        check("async_rst_step", 32'(rnd_step), 32'd0);
        check("async_rst_valid", 32'(sif.spawn_valid), 32'd0);
        @(posedge clk);
        #1;
        check_model();
        reset = 1'b1;
        step(1, 0, 4'h1, 0);
        check("restart_load", 32'(rnd_step), 32'd1);

        // Three accepted spawns, four stall cycles on the first
        run_to_spawn(4'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 4'h0, 0);
        step(1, 0, 4'h0, 1);
        run_to_spawn(4'h0);
        step(1, 0, 4'h0, 1);
        run_to_spawn(4'h0);
        step(1, 0, 4'h0, 1);
`ifdef SPAWN_STATS_EN
        check("stats_spawn_count", 32'(spawn_count), 32'd3);
        check("stats_stall_count", 32'(stall_count), 32'd4);
`endif

        for (int i = 0; i < 4000; i++)
            step($urandom_range(31) != 0, 1'($urandom), 4'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
